tile_fetch_sequencer: RTL

Sequences one scanline of 8-pixel tile rows into the 4-plane pixel shift register. It fetches each tile's attribute word from the tilemap port, then fetches its 32-bit graphics row from ROM, and stages the four plane bytes. It drives LOAD and the plane bytes so the shift register reloads every 8th CE_PIXEL, and it supplies the matching horizontal-flip select for the normal/reversed outputs.

---
 rtl/tile_fetch_sequencer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/tile_fetch_sequencer.sv
// rtl/tile_fetch_sequencer.sv - fetches tile attributes and graphics rows and stages them for the pixel shift register
module tile_fetch_sequencer #(
  parameter int TILES_PER_LINE = 42,
  parameter int CODE_W = 16,
  parameter int IDX_W = 6
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              CE_PIXEL,
  input  logic              line_start,
  input  logic [2:0]        line_row,
  output logic              attr_req,
  output logic [IDX_W-1:0]  attr_index,
  input  logic              attr_ack,
  input  logic [CODE_W-1:0] attr_code,
  input  logic              attr_hflip,
  input  logic              attr_vflip,
  output logic              rom_req,
  output logic [CODE_W+2:0] rom_addr,
  input  logic              rom_ack,
  input  logic [31:0]       rom_data,
  output logic              LOAD,
  output logic [7:0]        byte_1,
  output logic [7:0]        byte_2,
  output logic [7:0]        byte_3,
  output logic [7:0]        byte_4,
  output logic              hflip_sel,
  output logic              line_done,
  output logic              underrun
);

  typedef enum logic [1:0] {S_IDLE, S_ATTR, S_ROM, S_HOLD} state_t;

  localparam logic [IDX_W-1:0] LAST_TILE = IDX_W'(TILES_PER_LINE);

  state_t           state;
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] load_cnt;
  logic [2:0]       px;
  logic [2:0]       row;
  logic [2:0]       pend_row;
  logic             active;
  logic             staged;
  logic             restart_pending;
  logic             tile_hflip;
  logic             stage_hflip;
  logic [31:0]      stage_data;

  logic             attr_hit;
  logic             rom_hit;
  logic             restart;
  logic             stage_wr;
  logic             load_fire;
  logic             load_empty;
  logic [2:0]       new_row;

  // A restart waits for any outstanding handshake to complete; its data is then dropped.
  assign attr_hit   = attr_req & attr_ack;
  assign rom_hit    = rom_req & rom_ack;
  assign restart    = (line_start | restart_pending) & (~(attr_req | rom_req) | attr_hit | rom_hit);
  assign new_row    = line_start ? line_row : pend_row;
  assign stage_wr   = rom_hit & ~restart;
  assign LOAD       = active & (px == 3'd7);
  assign load_fire  = LOAD & CE_PIXEL;
  assign load_empty = LOAD & ~staged;
  assign byte_1     = load_empty ? 8'h00 : stage_data[7:0];
  assign byte_2     = load_empty ? 8'h00 : stage_data[15:8];
  assign byte_3     = load_empty ? 8'h00 : stage_data[23:16];
  assign byte_4     = load_empty ? 8'h00 : stage_data[31:24];

  // Fetch FSM: attribute request, ROM request, then hold until the stage is consumed.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      attr_req        <= 1'b0;
      attr_index      <= '0;
      rom_req         <= 1'b0;
      rom_addr        <= '0;
      fetch_idx       <= '0;
      row             <= 3'd0;
      pend_row        <= 3'd0;
      restart_pending <= 1'b0;
      tile_hflip      <= 1'b0;
      stage_hflip     <= 1'b0;
      stage_data      <= 32'h0;
    end else if (restart) begin
      state           <= S_ATTR;
      attr_req        <= 1'b1;
      attr_index      <= '0;
      rom_req         <= 1'b0;
      fetch_idx       <= '0;
      row             <= new_row;
      restart_pending <= 1'b0;
    end else begin
      if (line_start) begin
        restart_pending <= 1'b1;
        pend_row        <= line_row;
      end
      case (state)
        S_ATTR: begin
          if (attr_hit) begin
            attr_req   <= 1'b0;
            rom_req    <= 1'b1;
            tile_hflip <= attr_hflip;
            rom_addr   <= {attr_code, attr_vflip ? ~row : row};
            state      <= S_ROM;
          end
        end
        S_ROM: begin
          if (rom_hit) begin
            rom_req     <= 1'b0;
            stage_data  <= rom_data;
            stage_hflip <= tile_hflip;
            fetch_idx   <= fetch_idx + 1'b1;
            state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (!staged) begin
            if (fetch_idx < LAST_TILE) begin
              state      <= S_ATTR;
              attr_req   <= 1'b1;
              attr_index <= fetch_idx;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Pixel side: pixel phase, load accounting, stage ownership and line completion.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      px        <= 3'd0;
      active    <= 1'b0;
      staged    <= 1'b0;
      load_cnt  <= '0;
      hflip_sel <= 1'b0;
      underrun  <= 1'b0;
      line_done <= 1'b0;
    end else begin
      line_done <= 1'b0;
      if (load_fire) begin
        if (staged) begin
          hflip_sel <= stage_hflip;
        end else begin
          hflip_sel <= 1'b0;
          underrun  <= 1'b1;
        end
      end
      if (restart) begin
        px       <= 3'd7;
        active   <= 1'b1;
        staged   <= 1'b0;
        load_cnt <= '0;
      end else begin
        if (CE_PIXEL && active) px <= px + 3'd1;
        if (stage_wr) staged <= 1'b1;
        else if (load_fire) staged <= 1'b0;
        if (load_fire) begin
          load_cnt <= load_cnt + 1'b1;
          if (load_cnt + 1'b1 == LAST_TILE) begin
            active    <= 1'b0;
            line_done <= 1'b1;
          end
        end
      end
    end
  end

endmodule
